// File: rtl/vhd_controller.sv
// vhd_controller: memory-mapped virtual-disk controller.
// Holds a 512-byte sector buffer plus offset/command/ready registers and
// exchanges sectors with a host PC over an 8N1 serial link.
// Optional feature macro: VHD_RX_FRAME_CHECK_EN (drop received bytes whose
// stop bit samples low).
module vhd_controller #(
   parameter int CLK_FREQ    = 50_000_000,
   parameter int BAUD        = 115200,
   parameter int BUFFER_SIZE = 512
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RxD,
   output logic        TxD,
   input  logic [8:0]  VHDControlerAddr,
   input  logic        ChipSelect,
   input  logic [31:0] WriteData,
   input  logic        SaveHalf,
   input  logic        LoadHalf,
   input  logic        MemWrite,
   input  logic        MemRead,
   output logic [31:0] MemReadData,
   output logic        MemOK
);

   localparam int DIV  = CLK_FREQ / BAUD;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV + 1);
   localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
   localparam logic [8:0]    LAST_ADDR = 9'(BUFFER_SIZE - 1);

   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_REG  = 4'd1;
   localparam logic [3:0] S_BUF  = 4'd2;
   localparam logic [3:0] S_ACK  = 4'd3;
   localparam logic [3:0] S_DONE = 4'd4;
   localparam logic [3:0] S_HDR  = 4'd5;
   localparam logic [3:0] S_SEND = 4'd6;
   localparam logic [3:0] S_FIN  = 4'd7;
   localparam logic [3:0] S_RECV = 4'd8;

   // sector buffer
   logic [7:0]    mem [0:511];
   logic [8:0]    ram_addr;
   logic [7:0]    ram_rdata;
   logic [7:0]    ram_wdata;
   logic          ram_we;

   // transmitter
   logic          tx_start;
   logic [7:0]    tx_data;
   logic          tx_busy;
   logic [8:0]    tx_sh;
   logic [3:0]    tx_bit;
   logic [CW-1:0] tx_cnt;

   // receiver
   logic          rx_s1, rx_s2;
   logic          rx_active;
   logic [3:0]    rx_bit;
   logic [CW-1:0] rx_cnt;
   logic [7:0]    rx_sh;
   logic          rx_valid;
   logic          rx_accept;

   // controller
   logic [3:0]    state;
   logic [31:0]   offset;
   logic [15:0]   cmd;
   logic          ready;
   logic          req_write, req_half, req_wrap;
   logic [7:0]    req_idx;
   logic [31:0]   req_wdata;
   logic [8:0]    baddr;
   logic [1:0]    bstep;
   logic [31:0]   acc;
   logic          xfer_rd;
   logic [2:0]    hdr;
   logic [8:0]    ptr;
   logic          tx_idle_q;
   logic          wr_pend;
   logic [7:0]    wr_byte;

`ifdef VHD_RX_FRAME_CHECK_EN
   assign rx_accept = rx_s2;
`else
   assign rx_accept = 1'b1;
`endif

   assign ram_rdata = mem[ram_addr];

   // synchronous buffer write, contents survive reset
   always_ff @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
   end

   // buffer port and transmitter source selection by FSM state
   always_comb begin
      ram_addr  = baddr;
      ram_we    = 1'b0;
      ram_wdata = req_wdata[31:24];
      tx_start  = 1'b0;
      tx_data   = 8'h00;
      case (state)
         S_BUF: begin
            ram_we = req_write;
         end
         S_HDR: begin
            tx_start = !tx_busy;
            case (hdr)
               3'd0:    tx_data = offset[31:24];
               3'd1:    tx_data = offset[23:16];
               3'd2:    tx_data = offset[15:8];
               3'd3:    tx_data = offset[7:0];
               default: tx_data = cmd[7:0];
            endcase
         end
         S_SEND: begin
            ram_addr = ptr;
            tx_start = !tx_busy;
            tx_data  = ram_rdata;
         end
         S_RECV: begin
            ram_addr  = ptr;
            ram_we    = wr_pend;
            ram_wdata = wr_byte;
         end
         default: ;
      endcase
   end

   // 8N1 transmitter; a start is accepted in any cycle busy is low
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_busy <= 1'b0;
         TxD     <= 1'b1;
         tx_sh   <= '1;
         tx_bit  <= '0;
         tx_cnt  <= '0;
      end else if (!tx_busy) begin
         if (tx_start) begin
            tx_busy <= 1'b1;
            TxD     <= 1'b0;
            tx_sh   <= {1'b1, tx_data};
            tx_bit  <= '0;
            tx_cnt  <= '0;
         end
      end else if (tx_cnt == DIV_M1) begin
         tx_cnt <= '0;
         if (tx_bit == 4'd9) begin
            tx_busy <= 1'b0;
         end else begin
            TxD    <= tx_sh[0];
            tx_sh  <= {1'b1, tx_sh[8:1]};
            tx_bit <= tx_bit + 4'd1;
         end
      end else begin
         tx_cnt <= tx_cnt + 1'b1;
      end
   end

   // 8N1 receiver with 2-flop synchronizer, samples at mid-bit
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1     <= 1'b1;
         rx_s2     <= 1'b1;
         rx_active <= 1'b0;
         rx_bit    <= '0;
         rx_cnt    <= '0;
         rx_sh     <= '0;
         rx_valid  <= 1'b0;
      end else begin
         rx_s1    <= RxD;
         rx_s2    <= rx_s1;
         rx_valid <= 1'b0;
         if (!rx_active) begin
            if (!rx_s2) begin
               rx_active <= 1'b1;
               rx_cnt    <= '0;
               rx_bit    <= '0;
            end
         end else if (rx_cnt == ((rx_bit == 4'd0) ? HALF_M1 : DIV_M1)) begin
            rx_cnt <= '0;
            if (rx_bit == 4'd0) begin
               if (rx_s2) rx_active <= 1'b0;
               else       rx_bit    <= 4'd1;
            end else if (rx_bit == 4'd9) begin
               rx_active <= 1'b0;
               rx_valid  <= rx_accept;
            end else begin
               rx_sh  <= {rx_s2, rx_sh[7:1]};
               rx_bit <= rx_bit + 4'd1;
            end
         end else begin
            rx_cnt <= rx_cnt + 1'b1;
         end
      end
   end

   // bus slave and sector-transfer sequencer
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         offset      <= 32'h12345678;
         cmd         <= '0;
         ready       <= 1'b1;
         MemOK       <= 1'b0;
         MemReadData <= '0;
         req_write   <= 1'b0;
         req_half    <= 1'b0;
         req_wrap    <= 1'b0;
         req_idx     <= '0;
         req_wdata   <= '0;
         baddr       <= '0;
         bstep       <= '0;
         acc         <= '0;
         xfer_rd     <= 1'b0;
         hdr         <= '0;
         ptr         <= '0;
         tx_idle_q   <= 1'b0;
         wr_pend     <= 1'b0;
         wr_byte     <= '0;
      end else begin
         tx_idle_q <= !tx_busy;
         wr_pend   <= rx_valid && (state == S_RECV);
         wr_byte   <= rx_sh;
         case (state)
            S_IDLE: begin
               if ((cmd == 16'd1 || cmd == 16'd2) && !tx_busy && tx_idle_q) begin
                  ready   <= 1'b0;
                  xfer_rd <= (cmd == 16'd1);
                  hdr     <= '0;
                  ptr     <= '0;
                  state   <= S_HDR;
               end else if (ChipSelect && (MemWrite || MemRead)) begin
                  req_write   <= MemWrite;
                  req_half    <= MemWrite ? SaveHalf : LoadHalf;
                  req_wrap    <= &VHDControlerAddr[7:0];
                  req_idx     <= VHDControlerAddr[7:0];
                  // half stores are pre-aligned so bytes always leave from [31:24]
                  req_wdata   <= (MemWrite && SaveHalf && VHDControlerAddr[8]) ?
                                 {WriteData[15:0], 16'h0000} : WriteData;
                  baddr       <= {VHDControlerAddr[7:0], 1'b0};
                  bstep       <= '0;
                  acc         <= '0;
                  MemReadData <= '0;
                  state       <= VHDControlerAddr[8] ? S_BUF : S_REG;
               end
            end
            S_REG: begin
               MemOK <= 1'b1;
               state <= S_DONE;
               if (req_write) begin
                  case (req_idx)
                     8'hFC:   offset <= req_wdata;
                     8'hFE:   cmd    <= req_wdata[15:0];
                     default: ;
                  endcase
               end else begin
                  case (req_idx)
                     8'hFC:   MemReadData <= offset;
                     8'hFE:   MemReadData <= {16'h0000, cmd};
                     8'hFF:   MemReadData <= {31'h0, ready};
                     default: MemReadData <= '0;
                  endcase
               end
            end
            S_BUF: begin
               acc       <= {acc[23:0], ram_rdata};
               req_wdata <= {req_wdata[23:0], 8'h00};
               baddr     <= baddr + 9'd1;
               bstep     <= bstep + 2'd1;
               if ((bstep == 2'd1 && (req_half || req_wrap)) || bstep == 2'd3)
                  state <= S_ACK;
            end
            S_ACK: begin
               MemOK <= 1'b1;
               state <= S_DONE;
               if (!req_write) begin
                  if (req_half)      MemReadData <= {{16{acc[15]}}, acc[15:0]};
                  else if (req_wrap) MemReadData <= {acc[15:0], 16'h0000};
                  else               MemReadData <= acc;
               end
            end
            S_DONE: begin
               MemOK <= 1'b0;
               state <= S_IDLE;
            end
            S_HDR: begin
               if (!tx_busy) begin
                  hdr <= hdr + 3'd1;
                  if (hdr == 3'd4) begin
                     cmd   <= '0;
                     state <= xfer_rd ? S_RECV : S_SEND;
                  end
               end
            end
            S_SEND: begin
               if (!tx_busy) begin
                  ptr <= ptr + 9'd1;
                  if (ptr == LAST_ADDR) state <= S_FIN;
               end
            end
            S_FIN: begin
               if (!tx_busy) begin
                  ready <= 1'b1;
                  state <= S_IDLE;
               end
            end
            S_RECV: begin
               if (wr_pend) begin
                  ptr <= ptr + 9'd1;
                  if (ptr == LAST_ADDR) begin
                     ready <= 1'b1;
                     state <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vhd_controller.sv
// Directed testbench for vhd_controller (4 clocks per serial bit).
module tb_vhd_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        RxD = 1'b1;
   logic        TxD;
   logic [8:0]  VHDControlerAddr = '0;
   logic        ChipSelect = 1'b0;
   logic [31:0] WriteData = '0;
   logic        SaveHalf = 1'b0;
   logic        LoadHalf = 1'b0;
   logic        MemWrite = 1'b0;
   logic        MemRead = 1'b0;
   logic [31:0] MemReadData;
   logic        MemOK;

   int checks = 0;
   int fails  = 0;
   logic [7:0] txq[$];

   vhd_controller #(.CLK_FREQ(4), .BAUD(1), .BUFFER_SIZE(512)) dut (
      .clk(clk), .rst(rst), .RxD(RxD), .TxD(TxD),
      .VHDControlerAddr(VHDControlerAddr), .ChipSelect(ChipSelect),
      .WriteData(WriteData), .SaveHalf(SaveHalf), .LoadHalf(LoadHalf),
      .MemWrite(MemWrite), .MemRead(MemRead),
      .MemReadData(MemReadData), .MemOK(MemOK)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // host-side decoder of the DUT serial output
   initial begin
      forever begin
         @(negedge clk);
         if (TxD === 1'b0) begin
            logic [7:0] d;
            repeat (2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (4) @(negedge clk);
               d[i] = TxD;
            end
            repeat (4) @(negedge clk);
            txq.push_back(d);
         end
      end
   end

   // one bus transaction; exp_lat = 0 means the slave may be busy
   task automatic bus(input logic [8:0] a, input logic [31:0] wd, input logic wr,
                      input logic half, input int exp_lat, input logic [31:0] exp_rd,
                      input int maxw, input string tag);
      int n;
      bit seen;
      @(negedge clk);
      VHDControlerAddr = a;
      WriteData  = wd;
      MemWrite   = wr;
      MemRead    = 1'b1;
      SaveHalf   = wr & half;
      LoadHalf   = !wr & half;
      ChipSelect = 1'b1;
      n = 0;
      seen = 0;
      while (!seen && n < maxw) begin
         @(posedge clk);
         #1;
         n++;
         if (MemOK === 1'b1) seen = 1;
         if (n == 1 && exp_lat != 0) chk({tag, "_zero_at_e0"}, MemReadData, 32'h0);
      end
      ChipSelect = 1'b0;
      MemWrite   = 1'b0;
      MemRead    = 1'b0;
      SaveHalf   = 1'b0;
      LoadHalf   = 1'b0;
      chk({tag, "_memok"}, {31'h0, seen}, 32'h1);
      if (exp_lat != 0) chk({tag, "_latency"}, n - 1, exp_lat);
      if (!wr) chk({tag, "_data"}, MemReadData, exp_rd);
      @(posedge clk);
      #1;
      chk({tag, "_memok_fall"}, {31'h0, MemOK}, 32'h0);
   endtask

   task automatic uart_send(input logic [7:0] b);
      @(negedge clk);
      RxD = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         RxD = b[i];
         repeat (4) @(negedge clk);
      end
      RxD = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_frames(input int cnt, input int budget, input string tag);
      int c;
      c = 0;
      while (txq.size() < cnt && c < budget) begin
         @(posedge clk);
         c++;
      end
      chk(tag, txq.size(), cnt);
   endtask

   initial begin
      logic [7:0] exp_hdr [5];

      repeat (3) @(posedge clk);
      #1;
      chk("rst_memok", {31'h0, MemOK}, 32'h0);
      chk("rst_rdata", MemReadData, 32'h0);
      chk("rst_txd", {31'h0, TxD}, 32'h1);
      @(negedge clk);
      rst = 1'b0;

      // register map
      bus(9'h0FC, 0, 0, 0, 1, 32'h12345678, 20, "rd_offset");
      bus(9'h0FE, 0, 0, 0, 1, 32'h0, 20, "rd_cmd");
      bus(9'h0FF, 0, 0, 0, 1, 32'h1, 20, "rd_ready");
      bus(9'h0FF, 0, 1, 0, 1, 0, 20, "wr_ready");
      bus(9'h0FF, 0, 0, 0, 1, 32'h1, 20, "rd_ready_ro");
      bus(9'h010, 32'hFFFFFFFF, 1, 0, 1, 0, 20, "wr_other");
      bus(9'h010, 0, 0, 0, 1, 32'h0, 20, "rd_other");
      bus(9'h0FE, 32'hABCD0007, 1, 0, 1, 0, 20, "wr_cmd7");
      bus(9'h0FE, 0, 0, 0, 1, 32'h00000007, 20, "rd_cmd7");
      bus(9'h0FE, 32'h0, 1, 0, 1, 0, 20, "wr_cmd0");

      // buffer accesses
      bus(9'h110, 32'hA1B2C3D4, 1, 0, 5, 0, 20, "wr_word10");
      bus(9'h110, 0, 0, 1, 3, 32'hFFFFA1B2, 20, "rd_half10");
      bus(9'h111, 0, 0, 1, 3, 32'hFFFFC3D4, 20, "rd_half11");
      bus(9'h110, 0, 0, 0, 5, 32'hA1B2C3D4, 20, "rd_word10");
      bus(9'h120, 32'hDEAD1234, 1, 1, 3, 0, 20, "wr_half20");
      bus(9'h120, 0, 0, 1, 3, 32'h00001234, 20, "rd_half20");
      bus(9'h100, 32'hCAFEF00D, 1, 0, 5, 0, 20, "wr_word00");
      bus(9'h1FF, 32'h11223344, 1, 0, 3, 0, 20, "wr_wrap");
      bus(9'h1FF, 0, 0, 0, 3, 32'h11220000, 20, "rd_wrap");
      bus(9'h1FF, 0, 0, 1, 3, 32'h00001122, 20, "rd_half_ff");
      bus(9'h100, 0, 0, 0, 5, 32'hCAFEF00D, 20, "rd_word00_kept");

      // disk write: buffer[i] = i
      for (int k = 0; k < 128; k++)
         bus({1'b1, 8'(2 * k)}, {8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3)},
             1, 0, 5, 0, 20, "fill");
      bus(9'h0FC, 32'h00000003, 1, 0, 1, 0, 20, "wr_offset3");
      txq.delete();
      bus(9'h0FE, 32'h00000002, 1, 0, 1, 0, 20, "wr_cmd2");
      bus(9'h0FF, 0, 0, 0, 0, 32'h1, 30000, "rd_ready_after_c2");
      wait_frames(517, 200, "c2_frame_count");
      exp_hdr = '{8'h00, 8'h00, 8'h00, 8'h03, 8'h02};
      for (int i = 0; i < 5; i++)
         chk("c2_header", {24'h0, (txq.size() > i) ? txq[i] : 8'hXX}, {24'h0, exp_hdr[i]});
      for (int i = 0; i < 512; i++)
         chk("c2_data", {24'h0, (txq.size() > i + 5) ? txq[i + 5] : 8'hXX}, {24'h0, 8'(i)});
      bus(9'h0FE, 0, 0, 0, 1, 32'h0, 20, "rd_cmd_after_c2");

      // disk read: host returns 512 x 0x5A
      txq.delete();
      bus(9'h0FE, 32'h00000001, 1, 0, 1, 0, 20, "wr_cmd1");
      wait_frames(5, 400, "c1_header_count");
      exp_hdr = '{8'h00, 8'h00, 8'h00, 8'h03, 8'h01};
      for (int i = 0; i < 5; i++)
         chk("c1_header", {24'h0, (txq.size() > i) ? txq[i] : 8'hXX}, {24'h0, exp_hdr[i]});
      for (int i = 0; i < 512; i++) uart_send(8'h5A);
      bus(9'h0FF, 0, 0, 0, 0, 32'h1, 200, "rd_ready_after_c1");
      bus(9'h0FE, 0, 0, 0, 1, 32'h0, 20, "rd_cmd_after_c1");
      for (int k = 0; k < 128; k++)
         bus({1'b1, 8'(2 * k)}, 0, 0, 0, 5, 32'h5A5A5A5A, 20, "c1_buffer");

      // reset in the middle of a disk write
      bus(9'h0FE, 32'h00000002, 1, 0, 1, 0, 20, "wr_cmd2_abort");
      repeat (300) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_txd", {31'h0, TxD}, 32'h1);
      @(negedge clk);
      rst = 1'b0;
      bus(9'h0FF, 0, 0, 0, 1, 32'h1, 20, "abort_ready");
      bus(9'h0FE, 0, 0, 0, 1, 32'h0, 20, "abort_cmd");
      bus(9'h0FC, 0, 0, 0, 1, 32'h12345678, 20, "abort_offset");
      bus(9'h100, 0, 0, 0, 5, 32'h5A5A5A5A, 20, "abort_buffer_kept");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
